// File: rtl/cmp_pipe_if.sv
// Handshake bundle between the operand source / branch resolver and the cmp_pipe comparator.
// The slave view is the comparator itself; the master view is whoever drives operands and takes results.
interface cmp_pipe_if #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 4
);
  logic                  i_valid;
  logic                  o_ready;
  logic [DATA_WIDTH-1:0] i_elemA;
  logic [DATA_WIDTH-1:0] i_elemB;
  logic [2:0]            i_op;
  logic [TAG_WIDTH-1:0]  i_tag;
  logic                  i_flush;
  logic                  o_valid;
  logic                  i_ready;
  logic                  o_result;
  logic [TAG_WIDTH-1:0]  o_tag;

  modport master (
    output i_valid, i_elemA, i_elemB, i_op, i_tag, i_flush, i_ready,
    input  o_ready, o_valid, o_result, o_tag
  );

  modport slave (
    input  i_valid, i_elemA, i_elemB, i_op, i_tag, i_flush, i_ready,
    output o_ready, o_valid, o_result, o_tag
  );
endinterface

// File: rtl/cmp_pipe.sv
// Pipelined branch comparator: latency STAGES cycles, valid/ready both sides, bubbles collapse.
// o_ready falls only when every stage holds a stalled result; CMP_STATS_EN adds delivery counters.
module cmp_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 4,
  parameter int STAGES     = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  cmp_pipe_if.slave            bus
`ifdef CMP_STATS_EN
  ,
  input  logic                 i_stats_clr,
  output logic [CNT_WIDTH-1:0] o_total_cnt,
  output logic [CNT_WIDTH-1:0] o_taken_cnt
`endif
);

  localparam int OP_WIDTH = 3;

  typedef enum logic [OP_WIDTH-1:0] {
    OP_NOP = 3'd0, OP_EQ = 3'd1, OP_NE = 3'd2, OP_LT = 3'd3,
    OP_GE  = 3'd4, OP_LTU = 3'd5, OP_GEU = 3'd6, OP_LE = 3'd7
  } op_t;

  typedef struct packed {
    logic                 result;
    logic [TAG_WIDTH-1:0] tag;
  } ent_t;

  if (DATA_WIDTH < 2 || TAG_WIDTH < 1 || STAGES < 1 || CNT_WIDTH < 1) begin : g_bad_param
    $error("cmp_pipe: illegal parameter value");
  end

  logic              cmp_res;
  logic              lt_s;
  logic              lt_u;
  logic              eq;
  logic              accept;
  logic              full_run;
  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] src_vld;
  ent_t              stg     [STAGES];
  ent_t              src_ent [STAGES];

  assign eq   = (bus.i_elemA == bus.i_elemB);
  assign lt_s = ($signed(bus.i_elemA) < $signed(bus.i_elemB));
  assign lt_u = (bus.i_elemA < bus.i_elemB);

  always_comb begin
    cmp_res = 1'b0;
    case (op_t'(bus.i_op))
      OP_NOP:  cmp_res = 1'b0;
      OP_EQ:   cmp_res = eq;
      OP_NE:   cmp_res = ~eq;
      OP_LT:   cmp_res = lt_s;
      OP_GE:   cmp_res = ~lt_s;
      OP_LTU:  cmp_res = lt_u;
      OP_GEU:  cmp_res = ~lt_u;
      OP_LE:   cmp_res = lt_s | eq;
      default: cmp_res = 1'b0;
    endcase
  end

  // A stage is blocked only if it and every stage after it are full while the consumer stalls.
  always_comb begin
    full_run = 1'b1;
    adv      = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      full_run = full_run & vld[k];
      adv[k]   = vld[k] & ~(full_run & ~bus.i_ready);
    end
  end

  assign bus.o_ready = i_rst_n & ~bus.i_flush & (~vld[0] | adv[0]);
  assign accept      = bus.i_valid & bus.o_ready;

  always_comb begin
    src_vld    = '0;
    src_vld[0] = accept;
    src_ent[0] = '{result: cmp_res, tag: bus.i_tag};
    for (int k = 1; k < STAGES; k++) begin
      src_vld[k] = adv[k-1];
      src_ent[k] = stg[k-1];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld <= '0;
      for (int k = 0; k < STAGES; k++) stg[k] <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (bus.i_flush)
          vld[k] <= 1'b0;
        else if (!vld[k] || adv[k])
          vld[k] <= src_vld[k];
        if ((!vld[k] || adv[k]) && src_vld[k])
          stg[k] <= src_ent[k];
      end
    end
  end

  assign bus.o_valid  = vld[STAGES-1];
  assign bus.o_result = stg[STAGES-1].result;
  assign bus.o_tag    = stg[STAGES-1].tag;

`ifdef CMP_STATS_EN
  logic deliver;
  assign deliver = bus.o_valid & bus.i_ready;

  // Saturating counters; clear wins over a same-cycle delivery.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_total_cnt <= '0;
      o_taken_cnt <= '0;
    end else if (i_stats_clr) begin
      o_total_cnt <= '0;
      o_taken_cnt <= '0;
    end else if (deliver) begin
      if (o_total_cnt != '1)
        o_total_cnt <= o_total_cnt + 1'b1;
      if (bus.o_result && o_taken_cnt != '1)
        o_taken_cnt <= o_taken_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_cmp_pipe.sv
// Directed bench for cmp_pipe: scoreboard of {result, tag} pushed at accept, popped at deliver.
module tb_cmp_pipe;
  localparam int DW = 32;
  localparam int TW = 4;
  localparam int ST = 2;
`ifdef CMP_STATS_EN
  localparam int CW = 4;
`else
  localparam int CW = 16;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  cmp_pipe_if #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) bus ();

`ifdef CMP_STATS_EN
  logic          stats_clr;
  logic [CW-1:0] total_cnt;
  logic [CW-1:0] taken_cnt;
`endif

  cmp_pipe #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .STAGES(ST), .CNT_WIDTH(CW)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
`ifdef CMP_STATS_EN
    ,
    .i_stats_clr (stats_clr),
    .o_total_cnt (total_cnt),
    .o_taken_cnt (taken_cnt)
`endif
  );

  int          checks = 0;
  int          failures = 0;
  int          delivered = 0;
  int          n_acc;
  int          d0;
  logic        exp_r = 1'b0;
  logic        v;
  logic [2:0]  rop;
  logic [TW-1:0] held_tag;
  logic [TW:0] sb[$];
  logic [2:0]  s_op  [7] = '{3'd3, 3'd5, 3'd4, 3'd6, 3'd7, 3'd2, 3'd0};
  logic        s_exp [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic model(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] fa;
    logic [DW-1:0] fb;
    fa = a ^ {1'b1, {(DW-1){1'b0}}};
    fb = b ^ {1'b1, {(DW-1){1'b0}}};
    case (op)
      3'd1:    return a == b;
      3'd2:    return a != b;
      3'd3:    return fa < fb;
      3'd4:    return !(fa < fb);
      3'd5:    return a < b;
      3'd6:    return !(a < b);
      3'd7:    return (fa < fb) || (a == b);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [DW-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return 32'd1;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'hFFFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic vv, input logic [2:0] op, input logic [DW-1:0] a,
                       input logic [DW-1:0] b, input logic [TW-1:0] tag, input logic e);
    bus.i_valid = vv;
    bus.i_op    = op;
    bus.i_elemA = a;
    bus.i_elemB = b;
    bus.i_tag   = tag;
    exp_r       = e;
  endtask

  // Scoreboard: pop on deliver, drop everything on flush, push on accept.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.o_valid && bus.i_ready) begin
        delivered++;
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $error("FAIL sb_unexpected observed tag=%0h expected no result", bus.o_tag);
        end else begin
          chk("sb_result", {59'd0, bus.o_result, bus.o_tag}, {59'd0, sb.pop_front()});
        end
      end
      if (bus.i_flush) sb.delete();
      if (bus.i_valid && bus.o_ready) sb.push_back({exp_r, bus.i_tag});
    end
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_ready = 1'b1;
    bus.i_flush = 1'b0;
    drive(1'b0, 3'd0, '0, '0, '0, 1'b0);
`ifdef CMP_STATS_EN
    stats_clr = 1'b0;
`endif
    #1 rst_n = 1'b0;
    repeat (2) tick();
    chk("rst_o_valid", bus.o_valid, 0);
    chk("rst_o_ready", bus.o_ready, 0);
    chk("rst_o_result", bus.o_result, 0);
    chk("rst_o_tag", bus.o_tag, 0);
`ifdef CMP_STATS_EN
    chk("rst_total", total_cnt, 0);
    chk("rst_taken", taken_cnt, 0);
`endif
    @(negedge clk) rst_n = 1'b1;
    #1 chk("rst_release_ready", bus.o_ready, 1);
    tick();

    // First transaction latency.
    drive(1'b1, 3'd1, 32'd5, 32'd5, 4'd3, 1'b1);
    @(negedge clk) chk("lat_accept", bus.o_ready, 1);
    tick();
    bus.i_valid = 1'b0;
    @(negedge clk) chk("lat_n1_valid", bus.o_valid, 0);
    tick();
    @(negedge clk);
    chk("lat_n2_valid", bus.o_valid, 1);
    chk("lat_n2_result", bus.o_result, 1);
    chk("lat_n2_tag", bus.o_tag, 3);
    tick();
    chk("lat_after_valid", bus.o_valid, 0);

    // Signedness with A=-1, B=1; expected outcomes are fixed constants.
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, s_op[i], 32'hFFFF_FFFF, 32'd1, 4'(i), s_exp[i]);
      @(negedge clk) chk("sgn_accept", bus.o_ready, 1);
      tick();
    end
    bus.i_valid = 1'b0;
    repeat (ST + 2) tick();
    chk("sgn_drained", sb.size(), 0);

    // Back-pressure: six ops offered while the consumer stalls.
    d0 = delivered;
    bus.i_ready = 1'b0;
    n_acc = 0;
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, 3'd3, 32'(n_acc), 32'd2, 4'(n_acc), model(3'd3, 32'(n_acc), 32'd2));
      @(negedge clk) if (bus.o_ready) n_acc++;
      tick();
    end
    chk("bp_accepts", n_acc, ST);
    chk("bp_ready_low", bus.o_ready, 0);
    chk("bp_valid", bus.o_valid, 1);
    chk("bp_tag_head", bus.o_tag, 0);
    held_tag = bus.o_tag;
    tick();
    chk("bp_tag_stable", bus.o_tag, held_tag);
    bus.i_ready = 1'b1;
    for (int c = 0; c < 30 && n_acc < 6; c++) begin
      drive(1'b1, 3'd3, 32'(n_acc), 32'd2, 4'(n_acc), model(3'd3, 32'(n_acc), 32'd2));
      @(negedge clk) if (bus.o_ready) n_acc++;
      tick();
    end
    bus.i_valid = 1'b0;
    repeat (ST + 2) tick();
    chk("bp_all_accepted", n_acc, 6);
    chk("bp_delivered", delivered - d0, 6);
    chk("bp_sb_empty", sb.size(), 0);

    // Flush with two entries in flight and a new op offered.
    bus.i_ready = 1'b0;
    drive(1'b1, 3'd1, 32'd1, 32'd1, 4'd8, 1'b1);
    tick();
    drive(1'b1, 3'd1, 32'd1, 32'd2, 4'd9, 1'b0);
    tick();
    drive(1'b1, 3'd1, 32'd4, 32'd4, 4'd10, 1'b1);
    bus.i_flush = 1'b1;
    @(negedge clk) chk("flush_ready", bus.o_ready, 0);
    tick();
    bus.i_flush = 1'b0;
    bus.i_valid = 1'b0;
    @(negedge clk);
    chk("flush_o_valid", bus.o_valid, 0);
    chk("flush_ready_back", bus.o_ready, 1);
    chk("flush_sb_empty", sb.size(), 0);
    tick();
    bus.i_ready = 1'b1;
    drive(1'b1, 3'd1, 32'd7, 32'd7, 4'd11, 1'b1);
    @(negedge clk) chk("post_flush_accept", bus.o_ready, 1);
    tick();
    bus.i_valid = 1'b0;
    @(negedge clk) chk("post_flush_n1", bus.o_valid, 0);
    tick();
    @(negedge clk);
    chk("post_flush_n2", bus.o_valid, 1);
    chk("post_flush_tag", bus.o_tag, 11);
    tick();

    // Asynchronous reset in the middle of a stream.
    drive(1'b1, 3'd2, 32'd1, 32'd2, 4'd12, 1'b1);
    tick();
    drive(1'b1, 3'd2, 32'd3, 32'd3, 4'd13, 1'b0);
    tick();
    #2 rst_n = 1'b0;
    sb.delete();
    #1;
    chk("arst_o_valid", bus.o_valid, 0);
    chk("arst_o_ready", bus.o_ready, 0);
    bus.i_valid = 1'b0;
    repeat (2) tick();
    @(negedge clk) rst_n = 1'b1;
    #1;
    chk("arst_release_ready", bus.o_ready, 1);
    chk("arst_release_valid", bus.o_valid, 0);
    tick();

    // Random stream with random stalls, scored against the reference model.
    n_acc = 0;
    for (int c = 0; c < 400 && n_acc < 50; c++) begin
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      a = pick();
      b = ($urandom_range(0, 3) == 0) ? a : pick();
      rop = 3'($urandom_range(0, 7));
      v = ($urandom_range(0, 3) != 0);
      bus.i_ready = ($urandom_range(0, 3) != 0);
      drive(v, rop, a, b, 4'(n_acc), model(rop, a, b));
      @(negedge clk) if (v && bus.o_ready) n_acc++;
      tick();
    end
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    repeat (ST + 3) tick();
    chk("rnd_count", n_acc, 50);
    chk("rnd_sb_empty", sb.size(), 0);

`ifdef CMP_STATS_EN
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    chk("st_clr_total", total_cnt, 0);
    chk("st_clr_taken", taken_cnt, 0);
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 3'd1, (i < 9) ? 32'd0 : 32'd1, 32'd0, 4'(i), i < 9);
      @(negedge clk);
      tick();
    end
    bus.i_valid = 1'b0;
    repeat (ST + 2) tick();
    chk("st_total_sat", total_cnt, 15);
    chk("st_taken", taken_cnt, 9);
    drive(1'b1, 3'd1, 32'd0, 32'd0, 4'd5, 1'b1);
    @(negedge clk);
    tick();
    bus.i_valid = 1'b0;
    repeat (ST - 1) tick();
    stats_clr = 1'b1;
    @(negedge clk) chk("st_clr_deliver_vld", bus.o_valid, 1);
    tick();
    stats_clr = 1'b0;
    @(negedge clk);
    chk("st_clr_prio_total", total_cnt, 0);
    chk("st_clr_prio_taken", taken_cnt, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
